// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register target: FSM encodings, bus levels, counter widths.
package i2c_pkg;

    localparam int unsigned BITCNT_W = 3;
    localparam int unsigned STATE_W  = 4;

    localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [STATE_W-1:0] ST_ADDR       = 4'd1;
    localparam logic [STATE_W-1:0] ST_ADDR_ACK   = 4'd2;
    localparam logic [STATE_W-1:0] ST_PTR        = 4'd3;
    localparam logic [STATE_W-1:0] ST_PTR_ACK    = 4'd4;
    localparam logic [STATE_W-1:0] ST_WDATA      = 4'd5;
    localparam logic [STATE_W-1:0] ST_WDATA_ACK  = 4'd6;
    localparam logic [STATE_W-1:0] ST_RDATA      = 4'd7;
    localparam logic [STATE_W-1:0] ST_RDATA_MACK = 4'd8;
    localparam logic [STATE_W-1:0] ST_WAIT_STOP  = 4'd9;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus registered rise/fall pulses.
// Level output is delayed to stay aligned with the pulses; resets to the idle-bus level 1.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: pointer write, burst write and burst read
// with auto-increment. SCL/SDA are oversampled on sys_clk; SDA is driven open-drain.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR    = 7'd121,
    parameter int unsigned NREGS   = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_oe,
    output logic [8*NREGS-1:0]         regs,
    output logic                       wr_strobe,
    output logic [$clog2(NREGS)-1:0]   wr_index,
    output logic                       busy
);

    localparam int unsigned IDXW = $clog2(NREGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    logic [STATE_W-1:0]  state_q,     state_d;
    logic [BITCNT_W-1:0] bitcnt_q,    bitcnt_d;
    logic [7:0]          shift_q,     shift_d;
    logic [IDXW-1:0]     ptr_q,       ptr_d;
    logic                rw_q,        rw_d;
    logic                sda_oe_q,    sda_oe_d;
    logic                busy_q,      busy_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [IDXW-1:0]     wr_index_q,  wr_index_d;
    logic [8*NREGS-1:0]  regs_q,      regs_d;

    logic [7:0]          byte_in;
    logic [7:0]          rd_byte;
    logic [IDXW-1:0]     nxt_ptr;

    i2c_sync_edge u_scl (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .d_i     (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .d_i     (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            regs_q      <= {NREGS{RST_VAL}};
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

    // Bus events: START/STOP override any bit action in the same cycle.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        regs_d      = regs_q;
        byte_in     = {shift_q[6:0], sda_lvl};
        rd_byte     = regs_q[{ptr_q, 3'b000} +: 8];
        nxt_ptr     = ptr_q + IDXW'(1);

        if (start_c) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else if (stop_c) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (bitcnt_q == BITCNT_W'(7)) begin
                            bitcnt_d = '0;
                            if (byte_in[7:1] == ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d  = ST_WAIT_STOP;
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                            end
                        end
                    end
                end
                // bitcnt 0: waiting for the fall that opens the ACK slot; 1: ACK being driven.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bitcnt_q == '0) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            bitcnt_d = BITCNT_W'(1);
                        end else begin
                            bitcnt_d = '0;
                            sda_oe_d = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                                state_d  = ST_RDATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (bitcnt_q == BITCNT_W'(7)) begin
                            bitcnt_d = '0;
                            ptr_d    = byte_in[IDXW-1:0];
                            state_d  = ST_PTR_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (bitcnt_q == BITCNT_W'(7)) begin
                            bitcnt_d                       = '0;
                            regs_d[{ptr_q, 3'b000} +: 8] = byte_in;
                            wr_strobe_d                    = 1'b1;
                            wr_index_d                     = ptr_q;
                            ptr_d                          = nxt_ptr;
                            state_d                        = ST_WDATA_ACK;
                        end
                    end
                end
                // Shift register rotates; bit 6 is the next bit to present after each fall.
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == BITCNT_W'(7)) begin
                            bitcnt_d = '0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                            bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        end
                    end
                end
                ST_RDATA_MACK: begin
                    if (scl_rise && bitcnt_q == '0) begin
                        if (sda_lvl == ACK) begin
                            ptr_d    = nxt_ptr;
                            bitcnt_d = BITCNT_W'(1);
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && bitcnt_q == BITCNT_W'(1)) begin
                        bitcnt_d = '0;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        state_d  = ST_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign regs      = regs_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged controller on an open-drain bus,
// a register/pointer model, and scoreboards for write strobes and read bytes.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int unsigned Q = 60;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [31:0] regs;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int n_strobes = 0;
    int exp_strobes = 0;
    int exp_ptr = 0;
    logic [7:0] exp_regs [4];
    wr_t        wr_q [$];
    logic [7:0] rd_q [$];
    logic       watch = 1'b0;
    logic       saw_oe = 1'b0;
    logic       saw_busy = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regs #(
        .ADDR    (7'd121),
        .NREGS   (4),
        .RST_VAL (8'h00)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_io(input logic b, output logic s);
        #(Q) sda_m = b;
        #(Q) scl_m = 1'b1;
        #(Q) s = sda_bus;
        #(Q) scl_m = 1'b0;
    endtask

    task automatic start_cond();
        #(Q) sda_m = 1'b1;
        #(Q) scl_m = 1'b1;
        #(Q) sda_m = 1'b0;
        #(Q) scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        #(Q) sda_m = 1'b0;
        #(Q) scl_m = 1'b1;
        #(Q) sda_m = 1'b1;
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        check(tag, 32'(s), 32'(exp_ack));
    endtask

    task automatic send_ptr(input logic [7:0] b);
        exp_ptr = int'(b[1:0]);
        send_byte(b, ACK, "ptr_ack");
    endtask

    task automatic wr_data(input logic [7:0] b);
        wr_q.push_back({2'(exp_ptr), b});
        exp_regs[exp_ptr] = b;
        exp_ptr = (exp_ptr + 1) % 4;
        exp_strobes++;
        send_byte(b, ACK, "wdata_ack");
    endtask

    task automatic rd_byte(input logic mack, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        logic       s;
        rd_q.push_back(exp_regs[exp_ptr]);
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            got[i] = s;
        end
        bit_io(mack, s);
        exp = rd_q.pop_front();
        check(tag, 32'(got), 32'(exp));
        if (mack == ACK) exp_ptr = (exp_ptr + 1) % 4;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] e;
        e = {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
        check(tag, regs, e);
    endtask

    // Write-strobe scoreboard plus activity watch for the mismatch case.
    always @(negedge sys_clk) begin : mon
        wr_t w;
        if (watch) begin
            saw_oe   = saw_oe | sda_oe;
            saw_busy = saw_busy | busy;
        end
        if (sys_rst && wr_strobe) begin
            n_strobes++;
            check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_index", 32'(wr_index), 32'(w.idx));
                check("wr_data", 32'(regs[8*wr_index +: 8]), 32'(w.data));
            end
        end
    end

    initial begin
        logic s;
        for (int k = 0; k < 4; k++) exp_regs[k] = 8'h00;
        sys_rst = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        #100;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_index", 32'(wr_index), 32'd0);
        check_regs("rst_regs");
        sys_rst = 1'b1;
        #100;

        // Write burst from pointer 2
        start_cond();
        send_byte(8'hF2, ACK, "addr_w_ack");
        check("busy_after_ack", 32'(busy), 32'd1);
        send_ptr(8'h02);
        wr_data(8'hA5);
        wr_data(8'h5A);
        stop_cond();
        check_regs("write_regs");
        check("busy_after_stop", 32'(busy), 32'd0);

        // Combined read with repeated START, pointer wrap 3 -> 0
        start_cond();
        send_byte(8'hF2, ACK, "addr_w_ack2");
        send_ptr(8'h03);
        start_cond();
        send_byte(8'hF3, ACK, "addr_r_ack");
        rd_byte(ACK, "rd_byte0");
        rd_byte(NACK, "rd_byte1_wrap");
        #(Q);
        check("sda_rel_after_nack", 32'(sda_oe), 32'd0);
        check("busy_after_nack", 32'(busy), 32'd0);
        stop_cond();

        // Address mismatch: no ACK, no busy, no writes
        saw_oe = 1'b0;
        saw_busy = 1'b0;
        watch = 1'b1;
        start_cond();
        send_byte(8'h94, NACK, "mismatch_addr_nack");
        send_byte(8'h11, NACK, "mismatch_data_nack");
        stop_cond();
        watch = 1'b0;
        check("mismatch_saw_oe", 32'(saw_oe), 32'd0);
        check("mismatch_saw_busy", 32'(saw_busy), 32'd0);
        check_regs("mismatch_regs");

        // Abort mid-byte, then a normal transaction
        start_cond();
        send_byte(8'hF2, ACK, "abort_addr_ack");
        send_ptr(8'h01);
        for (int i = 0; i < 4; i++) bit_io(i[0], s);
        stop_cond();
        check_regs("abort_regs");
        check("abort_busy", 32'(busy), 32'd0);
        start_cond();
        send_byte(8'hF2, ACK, "post_abort_addr_ack");
        send_ptr(8'h01);
        wr_data(8'h3C);
        stop_cond();
        check_regs("post_abort_regs");

        // Reset while the target pulls SDA low (bit 6 of regs[2]=0xA5 is 0)
        start_cond();
        send_byte(8'hF3, ACK, "rst_rd_addr_ack");
        bit_io(1'b1, s);
        #(Q);
        check("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
        sys_rst = 1'b0;
        #1;
        check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) exp_regs[k] = 8'h00;
        exp_ptr = 0;
        check_regs("async_rst_regs");
        #49;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #50;
        sys_rst = 1'b1;
        #100;
        start_cond();
        send_byte(8'hF3, ACK, "post_rst_addr_ack");
        rd_byte(NACK, "post_rst_rd");
        stop_cond();

        // Back-to-back writes wrapping the bank twice; pointer upper bits ignored
        start_cond();
        send_byte(8'hF2, ACK, "b2b_addr_ack");
        send_ptr(8'hFC);
        for (int i = 1; i <= 8; i++) wr_data(8'((i << 4) | i));
        stop_cond();
        check_regs("b2b_regs");
        check("strobe_count", 32'(n_strobes), 32'(exp_strobes));
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
